// File: rtl/mult16_seq.sv
// mult16_seq -- sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// One multiplier bit is retired per CALC cycle. The whole operation takes
// WIDTH iterations between the start handshake and a one-cycle done pulse.
// The product register holds its value from done until the next done.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   start        in   request, only sampled in IDLE
//   multiplicand in   operand A, captured on an accepted start
//   multiplier   in   operand B, captured on an accepted start
//   busy         out  high while iterating (CALC)
//   done         out  one-cycle pulse, product valid
//   product      out  result, held until the next done
//
// Configuration macro: SIGNED_MULT_EN
//   Defined   -> two's-complement operands and product.
//   Undefined -> unsigned operation.
module mult16_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               last;
  logic [WIDTH:0]     sum;
  logic               fill;
  logic [2*WIDTH:0]   p_shift;

  // One iteration's add/subtract of the multiplicand into the high half.
  // hi_ext already carries the correct 17th bit (see its source below).
  function automatic logic [WIDTH:0] iter_sum(
    input logic [WIDTH:0]   hi_ext,
    input logic [WIDTH-1:0] a,
    input logic             add_en,
    input logic             sub_en
  );
    logic signed [WIDTH:0] h;
    logic signed [WIDTH:0] ax;
    h = $signed(hi_ext);
`ifdef SIGNED_MULT_EN
    ax = $signed({a[WIDTH-1], a});
`else
    ax = $signed({1'b0, a});
`endif
    if (!add_en)
      return h;
    else if (sub_en)
      return h - ax;
    else
      return h + ax;
  endfunction

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // The carry bit P[2W] always equals the extension of hi: it is zero in
  // unsigned mode, and in signed mode the arithmetic shift leaves it equal
  // to hi's sign bit. After a load both are zero. So {P[2W], hi} is the
  // properly extended high half in either mode.
  always_comb begin
`ifdef SIGNED_MULT_EN
    sum  = iter_sum(p_q[2*WIDTH:WIDTH], a_q, p_q[0], last);
    fill = sum[WIDTH];
`else
    sum  = iter_sum(p_q[2*WIDTH:WIDTH], a_q, p_q[0], 1'b0);
    fill = 1'b0;
`endif
    p_shift = {fill, sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand;
          p_d     = {{(WIDTH + 1){1'b0}}, multiplier};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        p_d   = p_shift;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // Capture the result on entry to DONE so it is valid with done.
          product_d = p_shift[2*WIDTH-1:0];
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult16_seq.sv
module tb_mult16_seq;

`ifdef SIGNED_MULT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  mult16_seq #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands with start for one edge; returns at the negedge after
  // the accepting edge (sample index 1).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
  endtask

  // Sample at negedges until done, bounded. lat is the sample index at
  // which done was seen (index 1 = first negedge after the accepting edge).
  task automatic wait_done(input int lat0, output int lat, output int busy_n,
                           output int overlap);
    lat     = lat0;
    busy_n  = 0;
    overlap = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy && done) overlap++;
      if (done) break;
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp);
    int lat, bn, ov;
    start_op(a, b);
    wait_done(1, lat, bn, ov);
    check({name, " latency"}, 32'(lat), 32'd17);
    check({name, " busy cycles"}, 32'(bn), 32'd16);
    check({name, " busy&done"}, 32'(ov), 32'd0);
    check({name, " product"}, product, exp);
    @(negedge clk);
    check({name, " done pulse width"}, {31'd0, done}, 32'd0);
    check({name, " product hold"}, product, exp);
  endtask

  initial begin
    int lat, bn, ov, extra, ndone, first_d, prev_d, bad_gap;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, SGN ? 32'h00000001 : 32'hFFFE0001};
    vecs[2] = '{16'h8000, 16'h0002, SGN ? 32'hFFFF0000 : 32'h00010000};
    vecs[3] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[4] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[5] = '{16'hFFFE, 16'h0003, SGN ? 32'hFFFFFFFA : 32'h0002FFFA};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[7] = '{16'h1234, 16'h0000, 32'h00000000};

    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset product", product, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

    // Start pulsed again mid-CALC must be ignored.
    start_op(16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    mcand  = 16'h0009;
    mplier = 16'h0009;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(6, lat, bn, ov);
    check("midstart latency", 32'(lat), 32'd17);
    check("midstart product", product, 32'h0000000F);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midstart extra done", 32'(extra), 32'd0);
    check("midstart product hold", product, 32'h0000000F);

    // Reset during CALC aborts the operation.
    start_op(16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort product", product, 32'd0);
    reset = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort no activity", 32'(extra), 32'd0);
    run_vec("after abort", 16'h0007, 16'h0009, 32'h0000003F);

    // Reset asserted together with start: reset wins.
    @(negedge clk);
    mcand  = 16'h0003;
    mplier = 16'h0003;
    start  = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    reset  = 1'b0;
    check("reset+start busy", {31'd0, busy}, 32'd0);

    // start held high: back-to-back products every 18 cycles.
    @(negedge clk);
    mcand   = 16'h0000;
    mplier  = 16'h1234;
    start   = 1'b1;
    ndone   = 0;
    first_d = 0;
    prev_d  = 0;
    bad_gap = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) first_d = c;
        else if (c - prev_d != 18) bad_gap++;
        prev_d = c;
      end
    end
    start = 1'b0;
    check("held first done", 32'(first_d), 32'd17);
    check("held done count", 32'(ndone), 32'd3);
    check("held done spacing", 32'(bad_gap), 32'd0);
    check("held product", product, 32'd0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
